// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: instruction-fetch port A, load/store port B,
// and the byte-wide RAM side. The arbiter uses the slave modport.
interface ram_arbiter_if;
    logic        a_req;
    logic [9:0]  a_address;
    logic [31:0] a_data_out;
    logic        a_ack;

    logic        b_req;
    logic        b_write;
    logic [1:0]  b_size;
    logic [9:0]  b_address;
    logic [31:0] b_data_in;
    logic [31:0] b_data_out;
    logic        b_ack;

    logic [9:0]  ram_address;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;
    logic        ram_write_enable;

    modport slave (
        input  a_req, a_address, b_req, b_write, b_size, b_address, b_data_in,
               ram_data_out,
        output a_data_out, a_ack, b_data_out, b_ack,
               ram_address, ram_data_in, ram_write_enable
    );

    modport master (
        output a_req, a_address, b_req, b_write, b_size, b_address, b_data_in,
               ram_data_out,
        input  a_data_out, a_ack, b_data_out, b_ack,
               ram_address, ram_data_in, ram_write_enable
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-port arbiter serialising 32-bit fetches (A) and byte/half/word loads and
// stores (B) onto a 1 KiB byte-wide RAM. RAM_ARB_ROUND_ROBIN_EN selects round-robin ties.
module ram_arbiter (
    input  logic         clk,
    input  logic         reset,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, FINISH, ACK} state_e;

    state_e      state_q, state_d;
    logic        port_b_q, port_b_d;
    logic        wr_q, wr_d;
    logic [9:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [2:0]  n_q, n_d;
    logic [2:0]  idx_q, idx_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] a_data_q, a_data_d;
    logic [31:0] b_data_q, b_data_d;
    logic        a_ack_q, a_ack_d;
    logic        b_ack_q, b_ack_d;
    logic        we_q, we_d;
    logic [9:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_din_q, ram_din_d;

    logic        tie_b;
    logic        grant_b;
    logic [2:0]  idx_nxt;
    logic [1:0]  prev_bi;
    logic [31:0] rd_byte;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic last_b_q, last_b_d;
    assign tie_b = !last_b_q;
`else
    assign tie_b = 1'b1;
`endif

    // RAM byte arriving now belongs to the address presented one cycle earlier.
    assign idx_nxt = idx_q + 3'd1;
    assign prev_bi = idx_q[1:0] - 2'd1;
    assign rd_byte = 32'(bus.ram_data_out) << {prev_bi, 3'b000};

    always_comb begin
        state_d    = state_q;
        port_b_d   = port_b_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        n_d        = n_q;
        idx_d      = idx_q;
        rdata_d    = rdata_q;
        a_data_d   = a_data_q;
        b_data_d   = b_data_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        we_d       = we_q;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        grant_b    = 1'b0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
        last_b_d   = last_b_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    grant_b  = bus.b_req && (!bus.a_req || tie_b);
                    port_b_d = grant_b;
                    wr_d     = grant_b && bus.b_write;
                    addr_d   = grant_b ? bus.b_address : bus.a_address;
                    wdata_d  = grant_b ? bus.b_data_in : 32'd0;
                    if (grant_b) begin
                        case (bus.b_size)
                            2'd0:    n_d = 3'd1;
                            2'd1:    n_d = 3'd2;
                            default: n_d = 3'd4;
                        endcase
                    end else begin
                        n_d = 3'd4;
                    end
                    idx_d      = 3'd0;
                    rdata_d    = 32'd0;
                    ram_addr_d = addr_d;
                    we_d       = wr_d;
                    ram_din_d  = wdata_d[7:0];
                    state_d    = ACCESS;
`ifdef RAM_ARB_ROUND_ROBIN_EN
                    last_b_d   = grant_b;
`endif
                end
            end
            ACCESS: begin
                idx_d = idx_nxt;
                if (!wr_q && idx_q != 3'd0)
                    rdata_d = rdata_q | rd_byte;
                if (idx_nxt == n_q) begin
                    state_d   = FINISH;
                    we_d      = 1'b0;
                    ram_din_d = 8'd0;
                end else begin
                    ram_addr_d = addr_q + {7'd0, idx_nxt};
                    we_d       = wr_q;
                    ram_din_d  = 8'(wdata_q >> {idx_nxt[1:0], 3'b000});
                end
            end
            FINISH: begin
                if (!wr_q) begin
                    if (port_b_q) b_data_d = rdata_q | rd_byte;
                    else          a_data_d = rdata_q | rd_byte;
                end
                a_ack_d = !port_b_q;
                b_ack_d = port_b_q;
                state_d = ACK;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            port_b_q   <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= 10'd0;
            wdata_q    <= 32'd0;
            n_q        <= 3'd0;
            idx_q      <= 3'd0;
            rdata_q    <= 32'd0;
            a_data_q   <= 32'd0;
            b_data_q   <= 32'd0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            we_q       <= 1'b0;
            ram_addr_q <= 10'd0;
            ram_din_q  <= 8'd0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_b_q   <= 1'b0;  // A counts as most recent, so B wins the first tie
`endif
        end else begin
            state_q    <= state_d;
            port_b_q   <= port_b_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            n_q        <= n_d;
            idx_q      <= idx_d;
            rdata_q    <= rdata_d;
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            we_q       <= we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            last_b_q   <= last_b_d;
`endif
        end
    end

    assign bus.a_data_out       = a_data_q;
    assign bus.b_data_out       = b_data_q;
    assign bus.a_ack            = a_ack_q;
    assign bus.b_ack            = b_ack_q;
    assign bus.ram_write_enable = we_q;
    assign bus.ram_address      = ram_addr_q;
    assign bus.ram_data_in      = ram_din_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: byte RAM model, reference byte array, and an
// ack scoreboard holding expected port, ack edge and load data.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic reset;
    ram_arbiter_if bus ();

    ram_arbiter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    typedef struct {
        logic        port_b;
        logic        wr;
        logic [31:0] data;
        int          ack_edge;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    logic [7:0] mem  [1024];
    logic [7:0] refm [1024];
    int edge_n = 0;
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;
    int we_before;
    int g;

    always @(posedge clk) begin
        if (bus.ram_write_enable) mem[bus.ram_address] <= bus.ram_data_in;
        bus.ram_data_out <= mem[bus.ram_address];
    end

    always @(posedge clk) edge_n <= edge_n + 1;
    always @(negedge clk) if (bus.ram_write_enable === 1'b1) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && (bus.a_ack === 1'b1 || bus.b_ack === 1'b1)) begin
            if (sb.size() == 0) begin
                chk("spurious_ack", {30'd0, bus.a_ack, bus.b_ack}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_port", {30'd0, bus.a_ack, bus.b_ack}, mon_e.port_b ? 32'd1 : 32'd2);
                chk("ack_edge", edge_n, mon_e.ack_edge);
                if (!mon_e.wr)
                    chk(mon_e.port_b ? "b_data_out" : "a_data_out",
                        mon_e.port_b ? bus.b_data_out : bus.a_data_out, mon_e.data);
            end
        end
    end

    function automatic logic [31:0] ref_rd(input logic [9:0] a, input int n);
        logic [31:0] r = 32'd0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = refm[10'(a + 10'(i))];
        return r;
    endfunction

    function automatic int size_n(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    task automatic push(input logic pb, input logic wr, input logic [31:0] d, input int ack_edge);
        exp_t e;
        e.port_b = pb; e.wr = wr; e.data = d; e.ack_edge = ack_edge;
        sb.push_back(e);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ack(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            step();
            n++;
        end
        chk("ack_timeout_pending", sb.size(), 32'd0);
        sb.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        chk("rst_a_ack", {31'd0, bus.a_ack}, 32'd0);
        chk("rst_b_ack", {31'd0, bus.b_ack}, 32'd0);
        chk("rst_a_data", bus.a_data_out, 32'd0);
        chk("rst_b_data", bus.b_data_out, 32'd0);
        chk("rst_we", {31'd0, bus.ram_write_enable}, 32'd0);
        chk("rst_ram_addr", {22'd0, bus.ram_address}, 32'd0);
        chk("rst_ram_din", {24'd0, bus.ram_data_in}, 32'd0);
        reset = 1'b0;
        step();
    endtask

    // Request from IDLE; request is dropped right after the grant edge.
    task automatic issue_b(input logic wr, input logic [1:0] sz, input logic [9:0] a,
                           input logic [31:0] d);
        int n = size_n(sz);
        bus.b_req = 1'b1; bus.b_write = wr; bus.b_size = sz;
        bus.b_address = a; bus.b_data_in = d;
        push(1'b1, wr, ref_rd(a, n), edge_n + 1 + n + 1);
        if (wr) for (int i = 0; i < n; i++) refm[10'(a + 10'(i))] = d[8*i +: 8];
        step();
        bus.b_req = 1'b0;
        wait_ack(20);
        step();
    endtask

    task automatic issue_a(input logic [9:0] a);
        bus.a_req = 1'b1; bus.a_address = a;
        push(1'b0, 1'b0, ref_rd(a, 4), edge_n + 6);
        step();
        bus.a_req = 1'b0;
        wait_ack(20);
        step();
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i]  = 8'(i) ^ 8'h5A;
            refm[i] = 8'(i) ^ 8'h5A;
        end
        bus.a_req = 1'b0; bus.a_address = 10'd0;
        bus.b_req = 1'b0; bus.b_write = 1'b0; bus.b_size = 2'd0;
        bus.b_address = 10'd0; bus.b_data_in = 32'd0;
        do_reset();

        we_before = we_cnt;
        issue_b(1'b1, 2'd2, 10'h010, 32'hDEADBEEF);
        chk("store_word_we_cycles", we_cnt - we_before, 32'd4);
        chk("mem_010", {24'd0, mem[10'h010]}, 32'hEF);
        chk("mem_011", {24'd0, mem[10'h011]}, 32'hBE);
        chk("mem_012", {24'd0, mem[10'h012]}, 32'hAD);
        chk("mem_013", {24'd0, mem[10'h013]}, 32'hDE);

        we_before = we_cnt;
        issue_a(10'h010);
        chk("fetch_value", bus.a_data_out, 32'hDEADBEEF);
        chk("fetch_no_we", we_cnt - we_before, 32'd0);

        issue_b(1'b1, 2'd1, 10'h3FF, 32'hFFFF1234);
        chk("mem_3ff", {24'd0, mem[10'h3FF]}, 32'h34);
        chk("mem_000_wrap", {24'd0, mem[10'h000]}, 32'h12);
        chk("mem_001_untouched", {24'd0, mem[10'h001]}, 32'h5B);
        issue_b(1'b0, 2'd2, 10'h3FE, 32'd0);
        chk("load_word_wrap", bus.b_data_out, 32'h5B1234A4);
        issue_b(1'b0, 2'd0, 10'h000, 32'd0);
        chk("load_byte_zext", bus.b_data_out, 32'h00000012);
        issue_b(1'b0, 2'd1, 10'h011, 32'd0);
        issue_b(1'b0, 2'd3, 10'h010, 32'd0);
        chk("a_data_held", bus.a_data_out, 32'hDEADBEEF);

        // Reset during the second ACCESS cycle of a word store.
        bus.b_req = 1'b1; bus.b_write = 1'b1; bus.b_size = 2'd2;
        bus.b_address = 10'h020; bus.b_data_in = 32'hAABBCCDD;
        step();
        bus.b_req = 1'b0;
        step();
        reset = 1'b1;
        step();
        chk("abort_a_ack", {31'd0, bus.a_ack}, 32'd0);
        chk("abort_b_ack", {31'd0, bus.b_ack}, 32'd0);
        chk("abort_we", {31'd0, bus.ram_write_enable}, 32'd0);
        chk("abort_ram_addr", {22'd0, bus.ram_address}, 32'd0);
        chk("abort_ram_din", {24'd0, bus.ram_data_in}, 32'd0);
        chk("abort_b_data", bus.b_data_out, 32'd0);
        chk("abort_a_data", bus.a_data_out, 32'd0);
        reset = 1'b0;
        refm[10'h020] = 8'hDD;
        refm[10'h021] = 8'hCC;
        repeat (8) step();
        chk("mem_020", {24'd0, mem[10'h020]}, 32'hDD);
        chk("mem_021", {24'd0, mem[10'h021]}, 32'hCC);
        chk("mem_022_unchanged", {24'd0, mem[10'h022]}, 32'h78);
        chk("mem_023_unchanged", {24'd0, mem[10'h023]}, 32'h79);
        issue_a(10'h020);
        chk("fetch_after_abort", bus.a_data_out, 32'h7978CCDD);

        // Both ports request together and hold for two transactions.
        do_reset();
        bus.a_req = 1'b1; bus.a_address = 10'h3FE;
        bus.b_req = 1'b1; bus.b_write = 1'b0; bus.b_size = 2'd2; bus.b_address = 10'h010;
        g = edge_n + 1;
        push(1'b1, 1'b0, 32'hDEADBEEF, g + 5);
`ifdef RAM_ARB_ROUND_ROBIN_EN
        push(1'b0, 1'b0, 32'h5B1234A4, g + 12);
        wait_ack(40);
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
`else
        push(1'b1, 1'b0, 32'hDEADBEEF, g + 12);
        wait_ack(40);
        // A was starved but must still be pending once B lets go.
        bus.b_req = 1'b0;
        push(1'b0, 1'b0, 32'h5B1234A4, edge_n + 7);
        wait_ack(20);
        bus.a_req = 1'b0;
`endif
        repeat (4) step();
        chk("final_idle_pending", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
- REQ-001 The block SHALL have no parameters; RAM depth is fixed at 1024 bytes, addressed by 10 bits.
- REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
- REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
- REQ-004 The block SHALL have port a_req, input, 1 bit: instruction-fetch request; always a 32-bit read.
- REQ-005 The block SHALL have port a_address, input, 10 bits: byte address of fetch.
- REQ-006 The block SHALL have port a_data_out, output, 32 bits: fetched word.
- REQ-007 The block SHALL have port a_ack, output, 1 bit: one-cycle completion pulse for port A.
- REQ-008 The block SHALL have port b_req, input, 1 bit: data load/store request.
- REQ-009 The block SHALL have port b_write, input, 1 bit: 1 store, 0 load.
- REQ-010 The block SHALL have port b_size, input, 2 bits: 0 byte, 1 half, 2 word, 3 treated as word.
- REQ-011 The block SHALL have port b_address, input, 10 bits: byte address of access.
- REQ-012 The block SHALL have port b_data_in, input, 32 bits: store data, low bytes used.
- REQ-013 The block SHALL have port b_data_out, output, 32 bits: load result, zero-extended.
- REQ-014 The block SHALL have port b_ack, output, 1 bit: one-cycle completion pulse for port B.
- REQ-015 The block SHALL have port ram_address, output, 10 bits: byte address driven to RAM.
- REQ-016 The block SHALL have port ram_data_in, output, 8 bits: byte written to RAM.
- REQ-017 The block SHALL have port ram_data_out, input, 8 bits: RAM read byte, valid the cycle after its address is presented with write disabled.
- REQ-018 The block SHALL have port ram_write_enable, output, 1 bit: RAM byte write strobe.

Function
- REQ-019 The block SHALL implement states IDLE, ACCESS, FINISH and ACK.
- REQ-020 In IDLE with a request pending, the block SHALL latch the requester, address, write flag, data and byte count N (1, 2 or 4), clear the byte index, and go to ACCESS.
- REQ-021 In ACCESS, ram_address SHALL equal (latched address + index) mod 1024; the index SHALL increment each cycle, and the block SHALL go to FINISH after N cycles.
- REQ-022 Address wrap SHALL be silent: 0x3FF+1 -> 0x000; misaligned accesses SHALL be permitted.
- REQ-023 In ACCESS for stores, ram_write_enable SHALL be 1 and ram_data_in SHALL be store byte[index], little-endian.
- REQ-024 ram_write_enable SHALL be 0 in every other state and in every load cycle.
- REQ-025 For loads, ram_data_out SHALL be captured into result byte[index-1] on each ACCESS cycle after the first, and the last byte SHALL be captured in FINISH; unread upper bytes SHALL be 0.
- REQ-026 FINISH SHALL go to ACK; in ACK the granted requester's ack SHALL be 1 for exactly one cycle; ACK SHALL go to IDLE; no grant SHALL occur in ACK.
- REQ-027 Latency SHALL be N+3 cycles from the grant edge to the ack cycle: word ack on cycle 7, byte on cycle 4.
- REQ-028 a_data_out and b_data_out SHALL be valid in the ack cycle and held until that port's next grant.
- REQ-029 A requester SHALL hold its request and fields until ack; deassertion mid-transaction SHALL NOT abort it, and the ack SHALL still pulse.
- REQ-030 A request still high in the cycle after ack SHALL be treated as a new request.
- REQ-031 The ungranted port SHALL wait with no ack, and its request SHALL NOT be lost.

Reset
- REQ-032 On reset the block SHALL set state to IDLE, a_ack and b_ack to 0, a_data_out and b_data_out to 0, ram_write_enable to 0, ram_address to 0 and ram_data_in to 0.
- REQ-033 Reset mid-transaction SHALL abort it with no ack; bytes already written SHALL remain in RAM.

Configuration
- REQ-034 When macro RAM_ARB_ROUND_ROBIN_EN is defined, a simultaneous a_req/b_req in IDLE SHALL be granted to the port not granted most recently; after reset, port B SHALL win first.
- REQ-035 When RAM_ARB_ROUND_ROBIN_EN is undefined, port B SHALL always win ties (fixed priority).

Verification
- REQ-036 Store word 0xDEADBEEF via B at 0x010 -> RAM[0x10..0x13] = EF,BE,AD,DE; b_ack on cycle 7 after grant.
- REQ-037 Port A fetch at 0x010 -> a_data_out = 0xDEADBEEF; a_ack single cycle; ram_write_enable never 1.
- REQ-038 Store half 0x1234 at 0x3FF, then load word at 0x3FE -> bytes at 0x3FF/0x000 = 34/12; wrap correct; byte load at 0x000 returns 0x00000012.
- REQ-039 a_req and b_req together, held high for two transactions -> fixed mode: B, B (A starved); RAM_ARB_ROUND_ROBIN_EN: B then A.
- REQ-040 Reset asserted on the 2nd ACCESS cycle of a word store of 0xAABBCCDD at 0x020 -> RAM[0x20..0x21] = DD,CC; [0x22..0x23] unchanged; no b_ack; all outputs 0.
- REQ-041 b_req dropped after grant -> transaction completes and b_ack still pulses.
